// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational instruction
// memory and buffers {instr, pc} pairs in a 2-entry FIFO drained by decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr_o,
  output logic        imem_rw_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        fetch_fault_o
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic        pop_s, push_s;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    instr0_d   = instr0_q;
    instr1_d   = instr1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    pop_s      = id_valid_o & id_ready_i;
    push_s     = (state_q == RUN) & ~redirect_valid_i & ((count_q < 2'd2) | pop_s);
    case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          count_d = 2'd0;
          if (redirect_pc_i[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            fetch_pc_d = redirect_pc_i;
          end
        end else if (push_s && pop_s) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_q == 2'd2) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = imem_data_i;
            pc1_d    = fetch_pc_q;
          end else begin
            instr0_d = imem_data_i;
            pc0_d    = fetch_pc_q;
          end
        end else if (push_s) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          count_d    = count_q + 2'd1;
          if (count_q == 2'd0) begin
            instr0_d = imem_data_i;
            pc0_d    = fetch_pc_q;
          end else begin
            instr1_d = imem_data_i;
            pc1_d    = fetch_pc_q;
          end
        end else if (pop_s) begin
          instr0_d = instr1_q;
          pc0_d    = pc1_q;
          count_d  = count_q - 2'd1;
        end else begin
          count_d = count_q;
        end
      end
      FAULT: begin
        count_d = 2'd0;
      end
      default: begin
        state_d = FAULT;
        count_d = 2'd0;
      end
    endcase
  end

  // State, fetch PC and FIFO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      instr0_q   <= 32'd0;
      instr1_q   <= 32'd0;
      pc0_q      <= 32'd0;
      pc1_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

  assign imem_addr_o   = {2'b00, fetch_pc_q[31:2]};
  assign imem_rw_o     = 1'b0;
  assign id_valid_o    = (count_q != 2'd0);
  assign id_instr_o    = id_valid_o ? instr0_q : 32'd0;
  assign id_pc_o       = id_valid_o ? pc0_q : 32'd0;
  assign id_pc_plus4_o = id_valid_o ? (pc0_q + 32'd4) : 32'd0;
  assign fetch_fault_o = (state_q == FAULT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, backpressure, redirects,
// PC wrap, misaligned-redirect fault and asynchronous reset.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_data, redirect_pc, id_instr, id_pc, id_pc_plus4;
  logic        imem_rw, redirect_valid, id_valid, id_ready, fetch_fault;
  logic [31:0] mem [32];
  int          checks = 0;
  int          errors = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_addr_o(imem_addr), .imem_rw_o(imem_rw), .imem_data_i(imem_data),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_instr_o(id_instr), .id_pc_o(id_pc), .id_pc_plus4_o(id_pc_plus4),
    .fetch_fault_o(fetch_fault)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, "_instr"}, id_instr, 32'd0);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_pc4"}, id_pc_plus4, 32'd0);
    check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] words [6];
    words[0] = 32'h0000_0000; words[1] = 32'h0010_8093; words[2] = 32'h0011_0113;
    words[3] = 32'h0020_8133; words[4] = 32'h0020_80b3; words[5] = 32'hffdf_f1ef;
    for (int i = 0; i < 32; i++) mem[i] = {16'hC0DE, 16'(i)};
    for (int i = 0; i < 6; i++) mem[i] = words[i];
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b1;

    // reset state and streaming with id_ready=1
    @(negedge clk);
    check_reset_vals("rst0");
    check("rw", {31'd0, imem_rw}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("st_valid", {31'd0, id_valid}, 32'd1);
      check("st_pc", id_pc, 32'(4 * i));
      check("st_instr", id_instr, words[i]);
      check("st_pc4", id_pc_plus4, 32'(4 * i + 4));
    end

    // backpressure: FIFO fills to 2, fetch PC holds at 8
    reset = 1'b1;
    #1;
    check_reset_vals("rst1");
    reset    = 1'b0;
    id_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, id_valid}, 32'd1);
      check("bp_pc", id_pc, 32'd0);
      check("bp_addr", imem_addr, (k == 1) ? 32'd1 : 32'd2);
    end
    id_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("rel_pc", id_pc, 32'(4 * j));
      check("rel_instr", id_instr, words[j]);
    end

    // redirect with FIFO full
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0014;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd_bubble", {31'd0, id_valid}, 32'd0);
    check("rd_addr", imem_addr, 32'd5);
    @(negedge clk);
    check("rd_valid", {31'd0, id_valid}, 32'd1);
    check("rd_pc", id_pc, 32'h0000_0014);
    check("rd_instr", id_instr, 32'hffdf_f1ef);
    @(negedge clk);
    check("rd_pc2", id_pc, 32'h0000_0018);
    check("rd_instr2", id_instr, 32'hC0DE_0006);

    // PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("wr_addr", imem_addr, 32'h3FFF_FFFF);
    check("wr_bubble", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    check("wr_pc", id_pc, 32'hFFFF_FFFC);
    check("wr_instr", id_instr, 32'hC0DE_001F);
    check("wr_pc4", id_pc_plus4, 32'h0000_0000);
    check("wr_addr0", imem_addr, 32'd0);
    @(negedge clk);
    check("wr_pc0", id_pc, 32'h0000_0000);
    check("wr_pc0_4", id_pc_plus4, 32'h0000_0004);
    check("wr_valid", {31'd0, id_valid}, 32'd1);

    // misaligned redirect -> sticky fault
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0006;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("ft_fault", {31'd0, fetch_fault}, 32'd1);
    check("ft_valid", {31'd0, id_valid}, 32'd0);
    check("ft_pc", id_pc, 32'd0);
    check("ft_addr", imem_addr, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("ft_valid2", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("ft_ign_fault", {31'd0, fetch_fault}, 32'd1);
    check("ft_ign_valid", {31'd0, id_valid}, 32'd0);
    check("ft_ign_addr", imem_addr, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst2");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rs_pc", id_pc, 32'd0);
    check("rs_valid", {31'd0, id_valid}, 32'd1);
    check("rs_fault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    check("rs_pc2", id_pc, 32'd4);
    check("rs_instr2", id_instr, 32'h0010_8093);

    // asynchronous reset between edges with FIFO full
    reset = 1'b1;
    #1;
    reset    = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_pre_addr", imem_addr, 32'd2);
    check("ar_pre_valid", {31'd0, id_valid}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("ar");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
